// File: rtl/prng_rr_server.sv
// Round-robin server that shares one 32-bit PRNG among NREQ requesters.
// Each grant issues one gen strobe, captures prng_q on gen_end and acks the winner.
module prng_rr_server #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 8
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] ack,
   output logic [31:0]     rnd_data,
   output logic            busy,
   output logic            err_timeout,
   output logic            err_zero,
   output logic [15:0]     serve_cnt,
   output logic            prng_gen,
   input  logic [31:0]     prng_q,
   input  logic            prng_gen_end
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_GEN, S_WAIT, S_ACK} state_t;

   state_t            r_state, w_state_nxt;
   logic [PW-1:0]     r_gnt, w_gnt_nxt;
   logic [PW-1:0]     r_ptr, w_ptr_nxt;
   logic [7:0]        r_wcnt, w_wcnt_nxt;
   logic [NREQ-1:0]   r_ack, w_ack_nxt;
   logic [31:0]       r_rnd, w_rnd_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_tmo, w_tmo_nxt;
   logic              r_errz, w_errz_nxt;
   logic [15:0]       r_cnt, w_cnt_nxt;
   logic              r_gen, w_gen_nxt;

   logic              w_found;
   logic [PW-1:0]     w_win;
   int                w_j;
   logic [7:0]        w_wcnt_inc;

   function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] g);
      return (int'(g) == NREQ - 1) ? '0 : g + 1'b1;
   endfunction

   // First asserted request at or after r_ptr, wrapping modulo NREQ
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_j     = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_j = int'(r_ptr) + i;
         if (w_j >= NREQ) w_j = w_j - NREQ;
         if (!w_found && req[w_j]) begin
            w_found = 1'b1;
            w_win   = PW'(w_j);
         end
      end
   end

   assign w_wcnt_inc = r_wcnt + 8'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_ptr_nxt   = r_ptr;
      w_wcnt_nxt  = r_wcnt;
      w_rnd_nxt   = r_rnd;
      w_errz_nxt  = r_errz;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = '0;
      w_gen_nxt   = 1'b0;
      w_tmo_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_gnt_nxt   = w_win;
               w_gen_nxt   = 1'b1;
               w_state_nxt = S_GEN;
            end
         end
         S_GEN: begin
            w_wcnt_nxt  = '0;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A completion in the same cycle as the timeout takes priority
            if (prng_gen_end) begin
               w_rnd_nxt            = prng_q;
               w_errz_nxt           = r_errz | (prng_q == 32'd0);
               w_ack_nxt[r_gnt]     = 1'b1;
               w_state_nxt          = S_ACK;
            end else if (w_wcnt_inc == 8'(TIMEOUT)) begin
               w_tmo_nxt   = 1'b1;
               w_ptr_nxt   = f_next_ptr(r_gnt);
               w_wcnt_nxt  = w_wcnt_inc;
               w_state_nxt = S_IDLE;
            end else begin
               w_wcnt_nxt  = w_wcnt_inc;
            end
         end
         S_ACK: begin
            w_cnt_nxt   = r_cnt + 16'd1;
            w_ptr_nxt   = f_next_ptr(r_gnt);
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_gnt   <= '0;
         r_ptr   <= '0;
         r_wcnt  <= '0;
         r_ack   <= '0;
         r_rnd   <= '0;
         r_busy  <= 1'b0;
         r_tmo   <= 1'b0;
         r_errz  <= 1'b0;
         r_cnt   <= '0;
         r_gen   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_ack   <= w_ack_nxt;
         r_rnd   <= w_rnd_nxt;
         r_busy  <= w_busy_nxt;
         r_tmo   <= w_tmo_nxt;
         r_errz  <= w_errz_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gen   <= w_gen_nxt;
      end
   end

   assign ack         = r_ack;
   assign rnd_data    = r_rnd;
   assign busy        = r_busy;
   assign err_timeout = r_tmo;
   assign err_zero    = r_errz;
   assign serve_cnt   = r_cnt;
   assign prng_gen    = r_gen;

endmodule

// File: tb/tb_prng_rr_server.sv
// Bench for prng_rr_server: behavioural PRNG, scoreboard of expected acks and values.
module tb_prng_rr_server;

   localparam int NR  = 4;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic [NR-1:0] req;
   logic [NR-1:0] ack;
   logic [31:0]   rnd_data;
   logic          busy;
   logic          err_timeout;
   logic          err_zero;
   logic [15:0]   serve_cnt;
   logic          prng_gen;
   logic [31:0]   prng_q;
   logic          prng_gen_end;

   prng_rr_server #(.NREQ(NR), .TIMEOUT(TMO)) dut (
      .clk(clk), .rstn(rstn), .req(req), .ack(ack), .rnd_data(rnd_data),
      .busy(busy), .err_timeout(err_timeout), .err_zero(err_zero),
      .serve_cnt(serve_cnt), .prng_gen(prng_gen), .prng_q(prng_q),
      .prng_gen_end(prng_gen_end)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] lfsr_next(input logic [31:0] q);
      return {q[30:0], q[31] ^ q[29] ^ q[25] ^ q[24]};
   endfunction

   // Behavioural PRNG: optional stall, seed load, gen_end the cycle after gen
   logic        m_load;
   logic [31:0] m_seed;
   logic        m_stall;
   logic [31:0] m_q;
   logic        m_end;

   always @(posedge clk) begin
      if (m_load) begin
         m_q   <= m_seed;
         m_end <= 1'b0;
      end else if (prng_gen && !m_stall) begin
         m_q   <= lfsr_next(m_q);
         m_end <= 1'b1;
      end else begin
         m_end <= 1'b0;
      end
   end

   assign prng_q       = m_q;
   assign prng_gen_end = m_end;

   typedef struct {
      logic [NR-1:0] a;
      logic [31:0]   d;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_q;
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          n_gen = 0;
   int          last_gen = -1;
   int          bad_gap = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [NR-1:0] a);
      exp_t e;
      ref_q = lfsr_next(ref_q);
      e.a = a;
      e.d = ref_q;
      sb.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (ack != '0) begin
            if (sb.size() == 0) begin
               chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("ack_idx", 32'(ack), 32'(e.a));
               chk("rnd_data", rnd_data, e.d);
            end
         end
         if (prng_gen) begin
            n_gen++;
            if (last_gen >= 0 && cyc - last_gen != 4) bad_gap++;
            last_gen = cyc;
         end
      end
   endtask

   task automatic load_seed(input logic [31:0] s);
      m_seed = s;
      m_load = 1'b1;
      @(negedge clk);
      m_load = 1'b0;
      ref_q  = s;
   endtask

   task automatic drive_until(input logic [NR-1:0] mask, input int nack, input bit drop,
                              output int first_lat);
      int n = 0;
      int c = 0;
      first_lat = -1;
      req = mask;
      while (n < nack && c < 200) begin
         @(negedge clk);
         c++;
         if (ack != '0) begin
            n++;
            if (first_lat < 0) first_lat = c;
            if (drop) req = req & ~ack;
         end
      end
      req = '0;
      chk("acks_seen", 32'(n), 32'(nack));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"}, 32'(ack), 32'd0);
      chk({tag, "_rnd"}, rnd_data, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_tmo"}, 32'(err_timeout), 32'd0);
      chk({tag, "_zero"}, 32'(err_zero), 32'd0);
      chk({tag, "_cnt"}, 32'(serve_cnt), 32'd0);
      chk({tag, "_gen"}, 32'(prng_gen), 32'd0);
   endtask

   initial begin
      int lat;
      int g;
      int t;
      logic [31:0] prev;

      rstn    = 1'b0;
      req     = '0;
      m_load  = 1'b1;
      m_seed  = 32'h1;
      m_stall = 1'b0;
      ref_q   = 32'h1;
      fork
         monitor();
      join_none
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      m_load = 1'b0;
      rstn   = 1'b1;
      @(negedge clk);

      // Single request from seed 1: value 2 after three edges
      push(4'b0001);
      drive_until(4'b0001, 1, 1'b1, lat);
      chk("lat_first", 32'(lat), 32'd3);
      @(negedge clk);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_cnt", 32'(serve_cnt), 32'd1);
      chk("t1_rnd", rnd_data, 32'h2);
      chk("t1_sb", 32'(sb.size()), 32'd0);

      // Fairness from ptr=0 with all requests held
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      for (int k = 0; k < 8; k++) push(NR'(1) << (k % NR));
      n_gen = 0;
      last_gen = -1;
      bad_gap = 0;
      drive_until(4'b1111, 8, 1'b0, lat);
      @(negedge clk);
      chk("fair_cnt", 32'(serve_cnt), 32'd8);
      chk("fair_gens", 32'(n_gen), 32'd8);
      chk("fair_gap", 32'(bad_gap), 32'd0);
      chk("fair_sb", 32'(sb.size()), 32'd0);

      // Serve 1 (ptr -> 2), then 0 and 1 together: 0 wins by wrap
      push(4'b0010);
      drive_until(4'b0010, 1, 1'b1, lat);
      push(4'b0001);
      push(4'b0010);
      drive_until(4'b0011, 2, 1'b1, lat);
      @(negedge clk);
      chk("wrap_sb", 32'(sb.size()), 32'd0);
      chk("wrap_cnt", 32'(serve_cnt), 32'd11);

      // Stalled PRNG: timeout TMO+1 edges after the gen strobe
      prev    = ref_q;
      m_stall = 1'b1;
      req     = 4'b0100;
      g = -1;
      t = -1;
      for (int k = 1; k <= 40 && t < 0; k++) begin
         @(negedge clk);
         if (prng_gen && g < 0) g = k;
         if (err_timeout) begin
            t = k;
            req = '0;
         end
      end
      chk("tmo_seen", 32'(t > 0), 32'd1);
      chk("tmo_delay", 32'(t - g), 32'(TMO + 1));
      @(negedge clk);
      chk("tmo_pulse", 32'(err_timeout), 32'd0);
      chk("tmo_rnd", rnd_data, prev);
      chk("tmo_cnt", 32'(serve_cnt), 32'd11);
      m_stall = 1'b0;
      push(4'b0100);
      drive_until(4'b0100, 1, 1'b1, lat);
      @(negedge clk);
      chk("post_tmo_cnt", 32'(serve_cnt), 32'd12);

      // Zero capture is sticky until reset
      load_seed(32'h0);
      push(4'b1000);
      drive_until(4'b1000, 1, 1'b1, lat);
      @(negedge clk);
      chk("zero_set", 32'(err_zero), 32'd1);
      load_seed(32'h5);
      push(4'b0001);
      drive_until(4'b0001, 1, 1'b1, lat);
      @(negedge clk);
      chk("zero_sticky", 32'(err_zero), 32'd1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("zero_clr", 32'(err_zero), 32'd0);

      // Reset during WAIT aborts; request is re-served afterwards
      m_stall = 1'b1;
      req = 4'b0010;
      t = 0;
      while (!prng_gen && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("rw_gen", 32'(prng_gen), 32'd1);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk_reset_outputs("rw");
      rstn = 1'b1;
      m_stall = 1'b0;
      push(4'b0010);
      drive_until(4'b0010, 1, 1'b1, lat);
      @(negedge clk);
      chk("rw_cnt", 32'(serve_cnt), 32'd1);
      chk("end_sb", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
